// File: rtl/uart_loop_buf.sv
// rtl/uart_loop_buf.sv - UART RX/TX pair with TX FIFO, loopback echo and host read/write ports
module uart_loop_buf #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     rx,
    output logic                     tx,
    input  logic                     loop_en,
    input  logic                     tx_en,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_ready,
    input  logic                     clr_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // receive side
    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    rx_state_t         rx_state;
    logic [CNT_W-1:0]  rx_clk_cnt;
    logic [BIT_W-1:0]  rx_bit_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic              word_valid;
    logic              rx_frame_bad;

    // transmit side and FIFO
    tx_state_t         tx_state;
    logic [CNT_W-1:0]  tx_clk_cnt;
    logic [BIT_W-1:0]  tx_bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic              full;
    logic              empty;
    logic              tx_slot;
    logic              pop;
    logic              push_req;
    logic              push_ok;
    logic              push_drop;
    logic              rd_drop;
    logic [DATA_W-1:0] push_data;

    // Two-flop synchroniser for the asynchronous rx pin, plus one more stage for edge detection
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX framing FSM; rx_shift holds the finished word while word_valid pulses
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_state     <= RX_IDLE;
            rx_clk_cnt   <= '0;
            rx_bit_cnt   <= '0;
            rx_shift     <= '0;
            word_valid   <= 1'b0;
            rx_frame_bad <= 1'b0;
        end else begin
            word_valid   <= 1'b0;
            rx_frame_bad <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_clk_cnt <= '0;
                    rx_bit_cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_clk_cnt == HALF_LAST) begin
                        rx_clk_cnt <= '0;
                        // a start bit gone high by mid-bit was a glitch
                        rx_state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_clk_cnt == BIT_LAST) begin
                        rx_clk_cnt <= '0;
                        rx_shift   <= {rx_sync, rx_shift[DATA_W-1:1]};
                        rx_bit_cnt <= rx_bit_cnt + BIT_W'(1);
                        if (rx_bit_cnt == DATA_LAST) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_clk_cnt == BIT_LAST) begin
                        rx_clk_cnt <= '0;
                        if (rx_sync) begin
                            word_valid <= 1'b1;
                            rx_state   <= RX_IDLE;
                        end else begin
                            rx_frame_bad <= 1'b1;
                            rx_state     <= RX_BREAK;
                        end
                    end else begin
                        rx_clk_cnt <= rx_clk_cnt + CNT_W'(1);
                    end
                end
                RX_BREAK: begin
                    // hold off until the line returns high so a long break is not a new start bit
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // FIFO and TX handshake decisions; loop_en selects the single push source
    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        wr_ready  = !full && !loop_en;
        tx_slot   = (tx_state == TX_IDLE) ||
                    ((tx_state == TX_STOP) && (tx_clk_cnt == BIT_LAST));
        pop       = tx_slot && !empty && tx_en;
        push_req  = loop_en ? word_valid : (wr_valid && wr_ready);
        push_data = loop_en ? rx_shift : wr_data;
        push_ok   = push_req && (!full || pop);
        push_drop = push_req && full && !pop;
        rd_drop   = word_valid && !loop_en && rd_valid && !rd_ready;
    end

    assign fifo_count = count;

    // FIFO storage; emptiness is tracked by count, so the array needs no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        end
    end

    // TX framing FSM; a pop from IDLE or the last stop cycle starts the next frame with no gap
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tx_state   <= TX_IDLE;
            tx_clk_cnt <= '0;
            tx_bit_cnt <= '0;
            tx_shift   <= '0;
            tx         <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_clk_cnt <= '0;
                    tx         <= 1'b1;
                end
                TX_START: begin
                    if (tx_clk_cnt == BIT_LAST) begin
                        tx_clk_cnt <= '0;
                        tx_bit_cnt <= '0;
                        tx         <= tx_shift[0];
                        tx_state   <= TX_DATA;
                    end else begin
                        tx_clk_cnt <= tx_clk_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_clk_cnt == BIT_LAST) begin
                        tx_clk_cnt <= '0;
                        if (tx_bit_cnt == DATA_LAST) begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx         <= tx_shift[1];
                            tx_shift   <= tx_shift >> 1;
                            tx_bit_cnt <= tx_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tx_clk_cnt <= tx_clk_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_clk_cnt == BIT_LAST) begin
                        tx_clk_cnt <= '0;
                        tx_state   <= TX_IDLE;
                    end else begin
                        tx_clk_cnt <= tx_clk_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
            if (pop) begin
                tx_state   <= TX_START;
                tx_clk_cnt <= '0;
                tx_shift   <= mem[rd_ptr];
                tx         <= 1'b0;
            end
        end
    end

    // Host read holding register; a word arriving while the host has not taken the last one is dropped
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (word_valid && !loop_en && (!rd_valid || rd_ready)) begin
            rd_data  <= rx_shift;
            rd_valid <= 1'b1;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

    // Sticky error flags; clr_err wins over an event in the same cycle
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_drop || rd_drop) begin
                overflow <= 1'b1;
            end
            if (rx_frame_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule
